mem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-ported `ram` simulation memory. It shares one memory interface between the instruction-fetch port (`i_*`) and the load/store port (`d_*`), and issues exactly one single-cycle read or write strobe per transaction. It returns a completion handshake to the owning port, generating completion itself for writes because the memory gives none. It also rejects misaligned or invalid-width accesses and times out reads that never see `mem_ready`.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory bus of the two-port arbiter
interface mem_arbiter_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_width;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_width;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] mem_addr;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_width;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_width,
    output i_rdata, i_ack, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_width,
    output d_rdata, d_ack, d_err,
    output mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width,
    input  mem_read_data, mem_ready
  );
  modport master (
    output i_req, i_we, i_addr, i_wdata, i_width,
    input  i_rdata, i_ack, i_err,
    output d_req, d_we, d_addr, d_wdata, d_width,
    input  d_rdata, d_ack, d_err,
    input  mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width,
    output mem_read_data, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-ported memory between fetch (i) and load/store (d) ports
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, FAULT = 2'd3;
  localparam int CW = $clog2(TIMEOUT);
  logic [1:0]    state;
  logic          last, owner, we_q;
  logic [CW-1:0] cnt;
  logic          any, win, we_w, legal, done, err;
  logic [31:0]   addr_w, wdata_w, rdata;
  logic [1:0]    width_w;
  always_comb begin
    any = bus.i_req | bus.d_req;
    win = (bus.i_req & bus.d_req) ? ~last : bus.d_req;
    we_w = win ? bus.d_we : bus.i_we;
    addr_w = win ? bus.d_addr : bus.i_addr;
    wdata_w = win ? bus.d_wdata : bus.i_wdata;
    width_w = win ? bus.d_width : bus.i_width;
    legal = (width_w == 2'd0) | ((width_w == 2'd1) & ~addr_w[0]) | ((width_w == 2'd2) & (addr_w[1:0] == 2'd0));
    // writes complete unconditionally; reads need mem_ready or give up at the timeout
    done = (state == FAULT) | ((state == WAIT) & (we_q | bus.mem_ready | (cnt == CW'(TIMEOUT - 1))));
    err = (state == FAULT) | ((state == WAIT) & ~we_q & ~bus.mem_ready);
    rdata = ((state == WAIT) & ~we_q & bus.mem_ready) ? bus.mem_read_data : '0;
    bus.i_ack = done & ~owner;
    bus.d_ack = done & owner;
    bus.i_err = done & err & ~owner;
    bus.d_err = done & err & owner;
    bus.i_rdata = owner ? '0 : rdata;
    bus.d_rdata = owner ? rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b0;
      owner <= 1'b0;
      we_q <= 1'b0;
      cnt <= '0;
      bus.mem_addr <= '0;
      bus.mem_read_valid <= 1'b0;
      bus.mem_write_valid <= 1'b0;
      bus.mem_write_data <= '0;
      bus.mem_width <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          last <= win;
          owner <= win;
          if (legal) begin
            bus.mem_addr <= addr_w;
            bus.mem_write_data <= wdata_w;
            bus.mem_width <= width_w;
            bus.mem_read_valid <= ~we_w;
            bus.mem_write_valid <= we_w;
            we_q <= we_w;
            state <= ISSUE;
          end else state <= FAULT;
        end
        ISSUE: begin
          bus.mem_read_valid <= 1'b0;
          bus.mem_write_valid <= 1'b0;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
